// File: rtl/uart_boot_pkg.sv
// Shared types and constants for the UART boot loader.
package uart_boot_pkg;
   typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_CSUM, S_DONE, S_ERR} boot_state_t;

   localparam int LEN_BYTES = 2;

   function automatic int clks_per_bit(input int clk_hz, input int baud);
      return clk_hz / baud;
   endfunction
endpackage

// File: rtl/uart_boot_loader_rx.sv
// 8N1 UART byte receiver: 2-FF synchroniser, mid-bit sampling, framing check.
module uart_rx_byte
   import uart_boot_pkg::*;
#(
   parameter int CLK_HZ = 10_000_000,
   parameter int BAUD   = 128_000
) (
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  logic       rx_i,
   output logic [7:0] byte_o,
   output logic       byte_vld_o,
   output logic       frame_err_o
);
   localparam int CPB   = clks_per_bit(CLK_HZ, BAUD);
   localparam int CNT_W = $clog2(CPB);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CPB / 2 - 1);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CPB - 1);

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

   rx_state_t        r_state;
   logic [2:0]       r_sync;
   logic [CNT_W-1:0] r_cnt;
   logic [2:0]       r_bit;
   logic [7:0]       r_shift;
   logic             r_vld;
   logic             r_ferr;

   logic w_rx;
   logic w_fall;

   // r_sync[1] is the synchronised line, r_sync[2] its previous value
   assign w_rx   = r_sync[1];
   assign w_fall = r_sync[2] & ~r_sync[1];

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_sync  <= 3'b111;
         r_state <= RX_IDLE;
         r_cnt   <= '0;
         r_bit   <= '0;
         r_shift <= '0;
         r_vld   <= 1'b0;
         r_ferr  <= 1'b0;
      end else begin
         r_sync <= {r_sync[1:0], rx_i};
         r_vld  <= 1'b0;
         r_ferr <= 1'b0;
         case (r_state)
            RX_IDLE: if (w_fall) begin
               r_state <= RX_START;
               r_cnt   <= '0;
            end
            RX_START: if (r_cnt == HALF_LAST) begin
               r_cnt   <= '0;
               r_bit   <= '0;
               r_state <= w_rx ? RX_IDLE : RX_DATA;
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
            RX_DATA: if (r_cnt == BIT_LAST) begin
               r_cnt   <= '0;
               r_shift <= {w_rx, r_shift[7:1]};
               if (r_bit == 3'd7) r_state <= RX_STOP;
               else               r_bit   <= r_bit + 1'b1;
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
            RX_STOP: if (r_cnt == BIT_LAST) begin
               r_vld   <= w_rx;
               r_ferr  <= ~w_rx;
               r_state <= RX_IDLE;
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
            default: r_state <= RX_IDLE;
         endcase
      end
   end

   assign byte_o      = r_shift;
   assign byte_vld_o  = r_vld;
   assign frame_err_o = r_ferr;
endmodule

// File: rtl/uart_boot_loader.sv
// UART program loader: streams length-prefixed little-endian words into BANKS targets.
// Define CHECKSUM_EN to require a trailing XOR checksum byte per bank.
module uart_boot_loader
   import uart_boot_pkg::*;
#(
   parameter int CLK_HZ      = 10_000_000,
   parameter int BAUD        = 128_000,
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 14,
   parameter int BANKS       = 2,
   parameter int TIMEOUT_CYC = 1_000_000
) (
   input  logic                                      clk_i,
   input  logic                                      rst_n_i,
   input  logic                                      start_i,
   input  logic                                      rx_i,
   output logic                                      wen_o,
   output logic [((BANKS > 1) ? $clog2(BANKS) : 1)-1:0] bank_o,
   output logic [ADDR_W-1:0]                         adr_o,
   output logic [DATA_W-1:0]                         dat_o,
   output logic                                      busy_o,
   output logic                                      done_o,
   output logic                                      err_o,
   output logic                                      cpu_rst_o
);
   localparam int BANK_W = (BANKS > 1) ? $clog2(BANKS) : 1;
   localparam int BYTES  = DATA_W / 8;
   localparam int BIDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam int TMO_W  = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
   localparam logic [TMO_W-1:0]  TMO_ONE   = TMO_W'(1);
   localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
   localparam logic [16:0]       LEN_MAX   = 17'(1) << ADDR_W;
   localparam logic              LIDX_LAST = 1'(LEN_BYTES - 1);
   localparam logic [BIDX_W-1:0] BIDX_LAST = BIDX_W'(BYTES - 1);

   boot_state_t       r_state;
   logic [BANK_W-1:0] r_bank;
   logic [ADDR_W-1:0] r_adr;
   logic [ADDR_W:0]   r_wcnt;
   logic [15:0]       r_len;
   logic              r_lidx;
   logic [BIDX_W-1:0] r_bidx;
   logic [DATA_W-1:0] r_dat;
   logic              r_wen;
   logic              r_done;
   logic              r_err;
   logic [TMO_W-1:0]  r_tmo;
`ifdef CHECKSUM_EN
   logic [7:0]        r_csum;
`endif

   logic [7:0]      w_byte;
   logic            w_vld;
   logic            w_ferr;
   logic            w_busy;
   logic            w_last_bank;
   logic            w_tmo_hit;
   logic [15:0]     w_len_in;
   logic [ADDR_W:0] w_wcnt_next;

   uart_rx_byte #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) u_rx (
      .clk_i       (clk_i),
      .rst_n_i     (rst_n_i),
      .rx_i        (rx_i),
      .byte_o      (w_byte),
      .byte_vld_o  (w_vld),
      .frame_err_o (w_ferr)
   );

   assign w_busy      = (r_state == S_LEN) || (r_state == S_DATA) || (r_state == S_CSUM);
   assign w_last_bank = (r_bank == BANK_W'(BANKS - 1));
   assign w_len_in    = {w_byte, r_len[7:0]};
   assign w_wcnt_next = r_wcnt + 1'b1;
   // r_tmo counts cycles since the last strobe, the strobe cycle itself being 1
   assign w_tmo_hit   = (TIMEOUT_CYC > 0) && (r_tmo == TMO_LAST) && !w_vld;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state <= S_IDLE;
         r_bank  <= '0;
         r_adr   <= '0;
         r_wcnt  <= '0;
         r_len   <= '0;
         r_lidx  <= 1'b0;
         r_bidx  <= '0;
         r_dat   <= '0;
         r_wen   <= 1'b0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
         r_tmo   <= '0;
`ifdef CHECKSUM_EN
         r_csum  <= '0;
`endif
      end else begin
         r_wen <= 1'b0;
         if (w_busy) r_tmo <= w_vld ? TMO_ONE : r_tmo + 1'b1;
         case (r_state)
            S_IDLE, S_DONE, S_ERR: if (start_i) begin
               r_state <= S_LEN;
               r_bank  <= '0;
               r_done  <= 1'b0;
               r_err   <= 1'b0;
               r_lidx  <= 1'b0;
               r_tmo   <= TMO_ONE;
`ifdef CHECKSUM_EN
               r_csum  <= '0;
`endif
            end
            S_LEN: if (w_vld) begin
`ifdef CHECKSUM_EN
               r_csum <= r_csum ^ w_byte;
`endif
               if (r_lidx != LIDX_LAST) begin
                  r_len[7:0] <= w_byte;
                  r_lidx     <= r_lidx + 1'b1;
               end else begin
                  r_len[15:8] <= w_byte;
                  r_lidx      <= 1'b0;
                  if (w_len_in == 16'd0) begin
`ifdef CHECKSUM_EN
                     r_state <= S_CSUM;
`else
                     r_state <= w_last_bank ? S_DONE : S_LEN;
                     r_done  <= w_last_bank;
                     if (!w_last_bank) r_bank <= r_bank + 1'b1;
`endif
                  end else if ({1'b0, w_len_in} > LEN_MAX) begin
                     r_state <= S_ERR;
                     r_err   <= 1'b1;
                  end else begin
                     r_state <= S_DATA;
                     r_adr   <= '0;
                     r_wcnt  <= '0;
                     r_bidx  <= '0;
                  end
               end
            end
            S_DATA: begin
               if (w_vld) begin
`ifdef CHECKSUM_EN
                  r_csum <= r_csum ^ w_byte;
`endif
                  r_dat[r_bidx*8 +: 8] <= w_byte;
                  if (r_bidx == BIDX_LAST) begin
                     r_bidx <= '0;
                     r_wen  <= 1'b1;
                  end else begin
                     r_bidx <= r_bidx + 1'b1;
                  end
               end
               // the address advances at the end of the write-strobe cycle
               if (r_wen) begin
                  r_adr  <= r_adr + 1'b1;
                  r_wcnt <= w_wcnt_next;
                  if ({1'b0, r_len} == 17'(w_wcnt_next)) begin
`ifdef CHECKSUM_EN
                     r_state <= S_CSUM;
`else
                     r_state <= w_last_bank ? S_DONE : S_LEN;
                     r_done  <= w_last_bank;
                     r_tmo   <= TMO_ONE;
                     if (!w_last_bank) r_bank <= r_bank + 1'b1;
`endif
                  end
               end
            end
`ifdef CHECKSUM_EN
            S_CSUM: if (w_vld) begin
               if (w_byte == r_csum) begin
                  r_state <= w_last_bank ? S_DONE : S_LEN;
                  r_done  <= w_last_bank;
                  r_csum  <= '0;
                  r_tmo   <= TMO_ONE;
                  if (!w_last_bank) r_bank <= r_bank + 1'b1;
               end else begin
                  r_state <= S_ERR;
                  r_err   <= 1'b1;
               end
            end
`endif
            default: ;
         endcase
         if (w_busy && (w_ferr || w_tmo_hit)) begin
            r_state <= S_ERR;
            r_err   <= 1'b1;
            r_wen   <= 1'b0;
         end
      end
   end

   assign wen_o     = r_wen;
   assign bank_o    = r_bank;
   assign adr_o     = r_adr;
   assign dat_o     = r_dat;
   assign busy_o    = w_busy;
   assign done_o    = r_done;
   assign err_o     = r_err;
   assign cpu_rst_o = w_busy;
endmodule
